// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// that retire BITS_PER_CYCLE bits per clock, followed by a one-cycle sign fixup.
module muldiv_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      function_3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int unsigned BPC   = BITS_PER_CYCLE;
    localparam int unsigned N     = XLEN / BPC;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP
    } state_e;

    state_e            state_q;
    op_e               op_q;
    logic [CNT_W-1:0]  counter_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   rem_q;
    logic              sign_a_q;
    logic              neg_q;
    logic              special_q;
    logic [XLEN-1:0]   special_val_q;
    logic [XLEN-1:0]   result_q;
    logic              result_valid_q;

    // Operand decode at accept time.
    logic            sgn_a_in, sgn_b_in;
    logic            neg_a_in, neg_b_in;
    logic [XLEN-1:0] mag_a_in, mag_b_in;
    logic            is_div_in, div_zero_in, div_ovf_in, special_in;
    logic [XLEN-1:0] special_val_in;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        sgn_a_in = 1'b0;
        sgn_b_in = 1'b0;
        case (op_e'(function_3))
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                sgn_a_in = 1'b1;
                sgn_b_in = 1'b1;
            end
            OP_MULHSU: sgn_a_in = 1'b1;
            default: ;
        endcase
    end

    assign neg_a_in    = sgn_a_in & operand_a[XLEN-1];
    assign neg_b_in    = sgn_b_in & operand_b[XLEN-1];
    assign mag_a_in    = neg_a_in ? -operand_a : operand_a;
    assign mag_b_in    = neg_b_in ? -operand_b : operand_b;
    assign is_div_in   = function_3[2];
    assign div_zero_in = (operand_b == '0);
    assign div_ovf_in  = ~function_3[0] & (operand_a == INT_MIN) & (operand_b == '1);
    assign special_in  = is_div_in & (div_zero_in | div_ovf_in);

    // function_3[1] separates REM* from DIV* among the divide opcodes.
    always_comb begin
        if (div_zero_in) special_val_in = function_3[1] ? operand_a : '1;
        else             special_val_in = function_3[1] ? '0 : operand_a;
    end

    // Multiply step: the low half of acc_q holds the not-yet-consumed multiplier bits.
    logic [XLEN+BPC-1:0] mul_sum;
    logic [2*XLEN-1:0]   mul_acc_d;

    assign mul_sum   = {{BPC{1'b0}}, acc_q[2*XLEN-1:XLEN]}
                     + ((XLEN+BPC)'(a_q) * (XLEN+BPC)'(acc_q[BPC-1:0]));
    assign mul_acc_d = {mul_sum, acc_q[XLEN-1:BPC]};

    // Restoring divide step; dividend shifts out of the quotient register as quotient bits enter.
    logic [XLEN-1:0] div_rem_d, div_quo_d;
    logic [XLEN:0]   trial;

    // NOTE: blocking assignments here chain the BPC sub-steps within one cycle; state uses <=.
    always_comb begin
        div_rem_d = rem_q;
        div_quo_d = acc_q[XLEN-1:0];
        trial     = '0;
        for (int i = 0; i < int'(BPC); i++) begin
            trial     = {div_rem_d, div_quo_d[XLEN-1]};
            div_quo_d = {div_quo_d[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, b_q}) begin
                trial        = trial - {1'b0, b_q};
                div_quo_d[0] = 1'b1;
            end
            div_rem_d = trial[XLEN-1:0];
        end
    end

    // Sign correction and output selection.
    logic [2*XLEN-1:0] prod_f;
    logic [XLEN-1:0]   quo_f, rem_f, result_d;

    assign prod_f = neg_q    ? -acc_q : acc_q;
    assign quo_f  = neg_q    ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_f  = sign_a_q ? -rem_q : rem_q;

    always_comb begin
        case (op_q)
            OP_MUL:                     result_d = prod_f[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_f[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            result_d = quo_f;
            default:                    result_d = rem_f;
        endcase
        if (special_q) result_d = special_val_q;
    end

    // NOTE: only control state and the visible result are reset; datapath registers are
    // always loaded at accept before being read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            counter_q      <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !flush) begin
                        op_q          <= op_e'(function_3);
                        a_q           <= mag_a_in;
                        b_q           <= mag_b_in;
                        acc_q         <= {{XLEN{1'b0}}, is_div_in ? mag_a_in : mag_b_in};
                        rem_q         <= '0;
                        sign_a_q      <= neg_a_in;
                        neg_q         <= neg_a_in ^ neg_b_in;
                        special_q     <= special_in;
                        special_val_q <= special_val_in;
                        counter_q     <= CNT_LAST;
                        state_q       <= special_in ? S_FIXUP : S_CALC;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        if (op_q[2]) begin
                            acc_q[XLEN-1:0] <= div_quo_d;
                            rem_q           <= div_rem_d;
                        end else begin
                            acc_q <= mul_acc_d;
                        end
                        if (counter_q == '0) state_q   <= S_FIXUP;
                        else                 counter_q <= counter_q - 1'b1;
                    end
                end
                S_FIXUP: begin
                    state_q <= S_IDLE;
                    if (!flush) begin
                        result_q       <= result_d;
                        result_valid_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready        = (state_q == S_IDLE);
    assign busy         = ~ready;
    assign result_valid = result_valid_q;
    assign result       = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: one BITS_PER_CYCLE=1 and one BITS_PER_CYCLE=4 instance
// checked against an arithmetic reference model.
module tb_muldiv_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_s [2];
    logic [2:0]  f3_s    [2];
    logic [31:0] a_s     [2];
    logic [31:0] b_s     [2];
    logic        flush_s [2];

    logic        rdy0, bsy0, rv0, rdy1, bsy1, rv1;
    logic [31:0] res0, res1;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_bpc1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .function_3(f3_s[0]),
        .operand_a(a_s[0]), .operand_b(b_s[0]), .flush(flush_s[0]),
        .ready(rdy0), .busy(bsy0), .result_valid(rv0), .result(res0)
    );

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_bpc4 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .function_3(f3_s[1]),
        .operand_a(a_s[1]), .operand_b(b_s[1]), .flush(flush_s[1]),
        .ready(rdy1), .busy(bsy1), .result_valid(rv1), .result(res1)
    );

    localparam logic [31:0] MIN32 = 32'h8000_0000;

    function automatic logic get_rdy(input int u);  return (u == 0) ? rdy0 : rdy1; endfunction
    function automatic logic get_bsy(input int u);  return (u == 0) ? bsy0 : bsy1; endfunction
    function automatic logic get_rv(input int u);   return (u == 0) ? rv0  : rv1;  endfunction
    function automatic logic [31:0] get_res(input int u); return (u == 0) ? res0 : res1; endfunction

    // Reference model: RV32M semantics with native wide/signed arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            3'd0: begin p = sa * sb;                                   return p[31:0];  end
            3'd1: begin p = sa * sb;                                   return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b});                 return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b};                   return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return a;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input int u, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == MIN32 && b == 32'hFFFF_FFFF))) return 1;
        return (u == 0) ? 33 : 9;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return MIN32;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op and wait for its completion; latency counts edges after the accepting edge.
    // With noise set, start/operands/function_3 are scrambled every cycle while the unit is busy.
    task automatic run_op(input int u, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit noise, output logic [31:0] res, output int lat, output bit ready_ok);
        start_s[u] = 1'b1; f3_s[u] = f; a_s[u] = a; b_s[u] = b; flush_s[u] = 1'b0;
        @(posedge clk); #1;
        start_s[u] = 1'b0;
        lat = 0;
        ready_ok = 1'b1;
        for (int e = 1; e <= 100; e++) begin
            if (noise) begin
                start_s[u] = 1'($urandom_range(0, 1));
                f3_s[u]    = 3'($urandom);
                a_s[u]     = $urandom;
                b_s[u]     = $urandom;
            end
            @(posedge clk); #1;
            if (get_rv(u)) begin
                lat = e;
                break;
            end
            if (get_rdy(u) !== 1'b0 || get_bsy(u) !== 1'b1) ready_ok = 1'b0;
        end
        start_s[u] = 1'b0;
        res = get_res(u);
    endtask

    task automatic wait_no_valid(input int u, input int cycles, output bit seen);
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (get_rv(u) !== 1'b0) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start_s[u] = 1'b0; f3_s[u] = '0; a_s[u] = '0; b_s[u] = '0; flush_s[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            checks += 4;
            if (get_rdy(u) !== 1'b1) begin failures++; $display("FAIL reset_ready u%0d: got %b want 1", u, get_rdy(u)); end
            if (get_bsy(u) !== 1'b0) begin failures++; $display("FAIL reset_busy u%0d: got %b want 0", u, get_bsy(u)); end
            if (get_rv(u)  !== 1'b0) begin failures++; $display("FAIL reset_valid u%0d: got %b want 0", u, get_rv(u)); end
            if (get_res(u) !== 32'd0) begin failures++; $display("FAIL reset_result u%0d: got %h want 0", u, get_res(u)); end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a, b, exp;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t        v [12];
        logic [31:0] res;
        int          lat;
        bit          rok;
        v[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        v[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
        v[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        v[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        v[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        v[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        v[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
        v[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
        v[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        v[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
        v[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        v[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        for (int i = 0; i < 12; i++) begin
            run_op(0, v[i].f, v[i].a, v[i].b, 1'b0, res, lat, rok);
            checks += 3;
            if (res !== v[i].exp) begin failures++; $display("FAIL dir_result #%0d: got %h want %h", i, res, v[i].exp); end
            if (lat != v[i].lat)  begin failures++; $display("FAIL dir_latency #%0d: got %0d want %0d", i, lat, v[i].lat); end
            if (!rok)             begin failures++; $display("FAIL dir_ready_busy #%0d: got ready high while busy want low", i); end
            @(posedge clk); #1;
            checks++;
            if (rv0 !== 1'b0) begin failures++; $display("FAIL dir_pulse #%0d: got valid %b want 0", i, rv0); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] prior, res;
        int          lat;
        bit          rok, seen;
        run_op(0, 3'd5, 32'd100, 32'd7, 1'b0, prior, lat, rok);
        checks++;
        if (prior !== 32'd14) begin failures++; $display("FAIL flush_prior: got %h want %h", prior, 32'd14); end
        @(posedge clk); #1;

        // Abort a DIV at the tenth edge after accept.
        start_s[0] = 1'b1; f3_s[0] = 3'd4; a_s[0] = $urandom; b_s[0] = 32'd3;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush_s[0] = 1'b1;
        @(posedge clk); #1;
        flush_s[0] = 1'b0;
        checks += 3;
        if (rdy0 !== 1'b1)  begin failures++; $display("FAIL flush_calc_ready: got %b want 1", rdy0); end
        if (rv0 !== 1'b0)   begin failures++; $display("FAIL flush_calc_valid: got %b want 0", rv0); end
        if (res0 !== prior) begin failures++; $display("FAIL flush_calc_result: got %h want %h", res0, prior); end
        wait_no_valid(0, 40, seen);
        checks++;
        if (seen) begin failures++; $display("FAIL flush_calc_late: got valid want none"); end

        // Flush landing on the FIXUP cycle of a special-case op.
        start_s[0] = 1'b1; f3_s[0] = 3'd5; a_s[0] = 32'd5; b_s[0] = 32'd0;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        flush_s[0] = 1'b1;
        @(posedge clk); #1;
        flush_s[0] = 1'b0;
        checks += 3;
        if (rv0 !== 1'b0)   begin failures++; $display("FAIL flush_fixup_valid: got %b want 0", rv0); end
        if (rdy0 !== 1'b1)  begin failures++; $display("FAIL flush_fixup_ready: got %b want 1", rdy0); end
        if (res0 !== prior) begin failures++; $display("FAIL flush_fixup_result: got %h want %h", res0, prior); end

        // Start and flush together: start dropped.
        start_s[0] = 1'b1; flush_s[0] = 1'b1; f3_s[0] = 3'd0; a_s[0] = 32'd3; b_s[0] = 32'd4;
        @(posedge clk); #1;
        start_s[0] = 1'b0; flush_s[0] = 1'b0;
        checks++;
        if (rdy0 !== 1'b1) begin failures++; $display("FAIL start_flush_ready: got %b want 1", rdy0); end
        wait_no_valid(0, 40, seen);
        checks++;
        if (seen) begin failures++; $display("FAIL start_flush_valid: got valid want none"); end

        run_op(0, 3'd0, 32'd3, 32'd4, 1'b0, res, lat, rok);
        checks++;
        if (res !== 32'd12) begin failures++; $display("FAIL flush_recover: got %h want %h", res, 32'd12); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        bit seen;
        start_s[0] = 1'b1; f3_s[0] = 3'd1; a_s[0] = $urandom; b_s[0] = $urandom;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks += 4;
        if (res0 !== 32'd0) begin failures++; $display("FAIL midrst_result: got %h want 0", res0); end
        if (rdy0 !== 1'b1)  begin failures++; $display("FAIL midrst_ready: got %b want 1", rdy0); end
        if (bsy0 !== 1'b0)  begin failures++; $display("FAIL midrst_busy: got %b want 0", bsy0); end
        if (rv0 !== 1'b0)   begin failures++; $display("FAIL midrst_valid: got %b want 0", rv0); end
        rst_n = 1'b1;
        wait_no_valid(0, 40, seen);
        checks++;
        if (seen) begin failures++; $display("FAIL midrst_late: got valid want none"); end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, res, exp;
        int          lat, elat;
        bit          rok;
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 30; i++) begin
                f = 3'($urandom);
                a = pick_operand();
                b = pick_operand();
                exp  = model(f, a, b);
                elat = exp_lat(u, f, a, b);
                run_op(u, f, a, b, (i % 2) == 1, res, lat, rok);
                checks += 3;
                if (res !== exp) begin failures++; $display("FAIL rand_result u%0d f%0d a=%h b=%h: got %h want %h", u, f, a, b, res, exp); end
                if (lat != elat) begin failures++; $display("FAIL rand_latency u%0d f%0d: got %0d want %0d", u, f, lat, elat); end
                if (!rok)        begin failures++; $display("FAIL rand_ready_busy u%0d f%0d: got ready high while busy want low", u, f); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f;
        logic [31:0] a, b, res, exp;
        int          lat;
        bit          rok;
        run_op(1, 3'd0, 32'd12345, 32'd6789, 1'b0, res, lat, rok);
        checks += 2;
        if (res !== 32'd83810205) begin failures++; $display("FAIL b2b_first: got %0d want %0d", res, 83810205); end
        if (lat != 9)             begin failures++; $display("FAIL b2b_first_latency: got %0d want 9", lat); end
        // Each following op is issued in the cycle the previous result_valid is high.
        for (int i = 0; i < 4; i++) begin
            f = 3'($urandom);
            a = $urandom;
            b = 32'($urandom_range(1, 32'h7FFF_FFFF));
            exp = model(f, a, b);
            run_op(1, f, a, b, 1'b0, res, lat, rok);
            checks += 2;
            if (res !== exp) begin failures++; $display("FAIL b2b_result #%0d f%0d: got %h want %h", i, f, res, exp); end
            if (lat != 9)    begin failures++; $display("FAIL b2b_latency #%0d: got %0d want 9", i, lat); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_reset_midop();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
